// File: rtl/wfid_rr_scheduler_pkg.sv
// rtl/wfid_rr_scheduler_pkg.sv - shared wavefront issue definitions: slot count, id width, state codes
package wfid_rr_scheduler_pkg;

   localparam int NUM_WF = 40;
   localparam int WFID_W = 6;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   typedef logic [WFID_W-1:0] wfid_t;
   typedef logic [NUM_WF-1:0] wf_mask_t;

   localparam logic [WFID_W:0] NUM_WF_EXT = NUM_WF[WFID_W:0];

   // Both operands are below NUM_WF, so one conditional subtract wraps the 7-bit sum.
   function automatic wfid_t wfid_add(input wfid_t a, input wfid_t b);
      logic [WFID_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= NUM_WF_EXT) begin
         sum = sum - NUM_WF_EXT;
      end
      return sum[WFID_W-1:0];
   endfunction

endpackage

// File: rtl/wfid_rr_scheduler_if.sv
// rtl/wfid_rr_scheduler_if.sv - request/grant bundle; stall_cycles present only with WFID_SCHED_STALL_CNT_EN
interface wfid_rr_scheduler_if;
   import wfid_rr_scheduler_pkg::*;

   wf_mask_t    req_valid;
   logic        flush;
   logic        grant_ready;
   logic        grant_valid;
   wfid_t       grant_wfid;
   wf_mask_t    grant_onehot;
   wfid_t       rr_ptr;
`ifdef WFID_SCHED_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   modport master (
`ifdef WFID_SCHED_STALL_CNT_EN
      output stall_cycles,
`endif
      input  req_valid, flush, grant_ready,
      output grant_valid, grant_wfid, grant_onehot, rr_ptr
   );

   modport slave (
`ifdef WFID_SCHED_STALL_CNT_EN
      input  stall_cycles,
`endif
      output req_valid, flush, grant_ready,
      input  grant_valid, grant_wfid, grant_onehot, rr_ptr
   );

endinterface

// File: rtl/wfid_rr_scheduler_pick.sv
// rtl/wfid_rr_scheduler_pick.sv - combinational round-robin pick: rotate, priority encode, un-rotate mod NUM_WF
module wfid_rr_pick
   import wfid_rr_scheduler_pkg::*;
(
   input  wf_mask_t req_valid,
   input  wfid_t    rr_ptr,
   output logic     any,
   output wfid_t    wfid
);

   wf_mask_t rot;
   wfid_t    off;

   // Doubling the vector makes the right shift a rotate; rr_ptr < NUM_WF keeps it in range.
   always_comb begin
      rot = wf_mask_t'({req_valid, req_valid} >> rr_ptr);
      off = '0;
      for (int i = NUM_WF - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = wfid_t'(i);
         end
      end
      any  = |req_valid;
      wfid = wfid_add(rr_ptr, off);
   end

endmodule

// File: rtl/wfid_rr_scheduler.sv
// rtl/wfid_rr_scheduler.sv - round-robin wavefront scheduler with registered grant; WFID_SCHED_STALL_CNT_EN adds stall_cycles
module wfid_rr_scheduler
   import wfid_rr_scheduler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   wfid_rr_scheduler_if.master  sched
);

   logic [0:0] state;
   wfid_t      grant_wfid_q;
   wf_mask_t   grant_onehot_q;
   wfid_t      rr_ptr_q;
   wfid_t      acc_ptr;
   wfid_t      pick_ptr;
   wfid_t      pick_wfid;
   logic       pick_any;
   logic       accept;

   // On accept the pick already sees the advanced pointer, giving one grant per cycle.
   always_comb begin
      accept   = (state == ST_HOLD) && sched.grant_ready && !sched.flush;
      acc_ptr  = wfid_add(grant_wfid_q, wfid_t'(1));
      pick_ptr = accept ? acc_ptr : rr_ptr_q;
   end

   wfid_rr_pick u_pick (
      .req_valid (sched.req_valid),
      .rr_ptr    (pick_ptr),
      .any       (pick_any),
      .wfid      (pick_wfid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         grant_wfid_q   <= '0;
         grant_onehot_q <= '0;
         rr_ptr_q       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!sched.flush && pick_any) begin
                  state          <= ST_HOLD;
                  grant_wfid_q   <= pick_wfid;
                  grant_onehot_q <= wf_mask_t'(1) << pick_wfid;
               end
            end
            ST_HOLD: begin
               if (sched.flush) begin
                  state          <= ST_IDLE;
                  grant_onehot_q <= '0;
               end else if (sched.grant_ready) begin
                  rr_ptr_q <= acc_ptr;
                  if (pick_any) begin
                     grant_wfid_q   <= pick_wfid;
                     grant_onehot_q <= wf_mask_t'(1) << pick_wfid;
                  end else begin
                     state          <= ST_IDLE;
                     grant_onehot_q <= '0;
                  end
               end
            end
            default: begin
               state          <= ST_IDLE;
               grant_onehot_q <= '0;
            end
         endcase
      end
   end

   assign sched.grant_valid  = (state == ST_HOLD);
   assign sched.grant_wfid   = grant_wfid_q;
   assign sched.grant_onehot = grant_onehot_q;
   assign sched.rr_ptr       = rr_ptr_q;

`ifdef WFID_SCHED_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((state == ST_HOLD) && !sched.grant_ready && !sched.flush && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign sched.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wfid_rr_scheduler.sv
// tb/tb_wfid_rr_scheduler.sv - randomized and directed bench for wfid_rr_scheduler against a slot-scan model
module tb_wfid_rr_scheduler;
   import wfid_rr_scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wfid_rr_scheduler_if sif();

   wfid_rr_scheduler dut (
      .clk   (clk),
      .rst   (rst),
      .sched (sif)
   );

   int checks = 0;
   int errors = 0;

   bit          m_valid;
   int          m_wfid;
   int          m_ptr;
   logic [31:0] m_stall;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [39:0] req, input int p);
      for (int k = 0; k < 40; k++) begin
         if (req[(p + k) % 40]) return (p + k) % 40;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_wfid  = 0;
      m_ptr   = 0;
      m_stall = '0;
   endtask

   task automatic compare_all();
      logic [63:0] exp_oh;
      exp_oh = m_valid ? (64'd1 << m_wfid) : 64'd0;
      check("grant_valid", 64'(sif.grant_valid), 64'(m_valid));
      if (m_valid) check("grant_wfid", 64'(sif.grant_wfid), 64'(m_wfid));
      check("grant_onehot", 64'(sif.grant_onehot), exp_oh);
      check("rr_ptr", 64'(sif.rr_ptr), 64'(m_ptr));
`ifdef WFID_SCHED_STALL_CNT_EN
      check("stall_cycles", 64'(sif.stall_cycles), 64'(m_stall));
`endif
   endtask

   task automatic step(input logic [39:0] req, input logic fl, input logic rdy);
      bit          n_valid;
      int          n_wfid;
      int          n_ptr;
      logic [31:0] n_stall;
      int          p;
      sif.req_valid   = req;
      sif.flush       = fl;
      sif.grant_ready = rdy;
      n_valid = m_valid;
      n_wfid  = m_wfid;
      n_ptr   = m_ptr;
      n_stall = m_stall;
      if (m_valid) begin
         if (!fl && !rdy && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
         if (fl) begin
            n_valid = 1'b0;
         end else if (rdy) begin
            n_ptr = (m_wfid + 1) % 40;
            p = model_pick(req, n_ptr);
            n_valid = (p >= 0);
            if (p >= 0) n_wfid = p;
         end
      end else if (!fl) begin
         p = model_pick(req, m_ptr);
         if (p >= 0) begin
            n_valid = 1'b1;
            n_wfid  = p;
         end
      end
      @(posedge clk);
      #1;
      m_valid = n_valid;
      m_wfid  = n_wfid;
      m_ptr   = n_ptr;
      m_stall = n_stall;
      compare_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(sif.grant_valid), 64'd0);
      check({tag, "_wfid"}, 64'(sif.grant_wfid), 64'd0);
      check({tag, "_onehot"}, 64'(sif.grant_onehot), 64'd0);
      check({tag, "_ptr"}, 64'(sif.rr_ptr), 64'd0);
`ifdef WFID_SCHED_STALL_CNT_EN
      check({tag, "_stall"}, 64'(sif.stall_cycles), 64'd0);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [39:0] rand_req();
      logic [63:0] w;
      logic [63:0] m;
      w = {$urandom(), $urandom()};
      m = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
         0: w = '0;
         1: w = w & m;
         2: w = 64'd1 << $urandom_range(0, 39);
         default: ;
      endcase
      return w[39:0];
   endfunction

   logic [31:0] stall_base;
   int          ptr_before;

   initial begin
      rst             = 1'b1;
      sif.req_valid   = '0;
      sif.flush       = 1'b0;
      sif.grant_ready = 1'b0;
      model_reset();
      do_reset();

      // reset asserted while a grant is held clears outputs immediately
      step(40'd1 << 7, 1'b0, 1'b0);
      check("hold_before_rst", 64'(sif.grant_valid), 64'd1);
      #3 rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // bits {0,5}: back-to-back grants, then idle with pointer 6
      step(40'h21, 1'b0, 1'b1);
      check("t2_first", 64'(sif.grant_wfid), 64'd0);
      step(40'h20, 1'b0, 1'b1);
      check("t2_second", 64'(sif.grant_wfid), 64'd5);
      step(40'h0, 1'b0, 1'b1);
      check("t2_ptr", 64'(sif.rr_ptr), 64'd6);
      check("t2_idle", 64'(sif.grant_valid), 64'd0);

      // slot 39 wraps the pointer to 0, then 0 outranks 39
      step(40'd1 << 39, 1'b0, 1'b1);
      check("t3_grant39", 64'(sif.grant_wfid), 64'd39);
      step(40'h0, 1'b0, 1'b1);
      check("t3_wrap_ptr", 64'(sif.rr_ptr), 64'd0);
      step((40'd1 << 39) | 40'd1, 1'b0, 1'b0);
      check("t3_wrap_pick", 64'(sif.grant_wfid), 64'd0);
      step(40'h0, 1'b0, 1'b1);

      // held grant stays stable while requests change under backpressure
      step(40'd1 << 7, 1'b0, 1'b0);
      stall_base = m_stall;
      for (int i = 0; i < 5; i++) begin
         step(rand_req(), 1'b0, 1'b0);
         check("t4_stable", 64'(sif.grant_wfid), 64'd7);
      end
`ifdef WFID_SCHED_STALL_CNT_EN
      check("t4_stall5", 64'(sif.stall_cycles - stall_base), 64'd5);
`endif
      step(40'h0, 1'b0, 1'b1);

      // flush beats ready and leaves the pointer alone
      step(40'd1 << 3, 1'b0, 1'b0);
      ptr_before = int'(sif.rr_ptr);
      step(40'hFF_FFFF_FFFF, 1'b1, 1'b1);
      check("t5_flush_valid", 64'(sif.grant_valid), 64'd0);
      check("t5_flush_ptr", 64'(sif.rr_ptr), 64'(ptr_before));

      // full request set sweeps every slot with no gaps
      do_reset();
      step(40'hFF_FFFF_FFFF, 1'b0, 1'b1);
      for (int k = 0; k < 41; k++) begin
         check("t6_sweep", 64'(sif.grant_wfid), 64'(k % 40));
         check("t6_nogap", 64'(sif.grant_valid), 64'd1);
         step(40'hFF_FFFF_FFFF, 1'b0, 1'b1);
      end

      for (int n = 0; n < 3000; n++) begin
         step(rand_req(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
